block_dispatcher: RTL and testbench
===================================

# block_dispatcher

Parametrised successor to the single-kernel block dispatch unit. Sits at the GPU top level between the kernel launch interface and the compute cores. Splits a kernel's thread count into fixed-size blocks and hands them to idle, enabled cores, using round-robin core selection and out-of-order completion tracking. Supports back-to-back launches through a start/busy/done handshake and a runtime core-enable mask.

## Interface
- NUM_CORES, 4: number of compute cores driven.
- THREADS_PER_BLOCK, 4: threads per full block; must be ≥1.
- THREAD_W, 16: width of `thread_count` and of block IDs.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: launch pulse; sampled only in IDLE, ignored otherwise.
- `thread_count` in THREAD_W: total kernel threads; latched on an accepted `start`.
- `core_enable` in NUM_CORES: cores allowed to receive new blocks; sampled every dispatch cycle.
- `core_done` in NUM_CORES: per-core block completion; meaningful only while that core's `core_start` is 1.
- `core_start` out NUM_CORES: level, held from dispatch until `core_done`.
- `core_reset` out NUM_CORES: per-core reset strobe.
- `core_block_id[NUM_CORES]` out THREAD_W: block index of the current assignment.
- `core_thread_count[NUM_CORES]` out $clog2(THREADS_PER_BLOCK)+1: live threads in the assigned block.
- `busy` out 1: high from an accepted `start` until `done`, inclusive.
- `done` out 1: one-cycle pulse at kernel completion.

## Operation
- States: IDLE, RESET_CORES, DISPATCH, DONE.
- IDLE, on `start`=1:
  - latch `thread_count`;
  - compute and register `total_blocks` = ceil(thread_count / THREADS_PER_BLOCK), evaluated in THREAD_W+1 bits (no overflow at max count);
  - clear `blocks_dispatched`, `blocks_done` and the core free mask;
  - go to RESET_CORES.
- RESET_CORES (1 cycle):
  - `core_reset`=all ones and `core_start`=0;
  - all cores marked free;
  - go to DISPATCH, or to DONE if `total_blocks`=0.
- DISPATCH, dispatch side:
  - each cycle, if `blocks_dispatched` < `total_blocks` and (free & `core_enable`) ≠ 0, the round-robin arbiter grants one core;
  - on a grant, register `core_start[g]`=1 and `core_block_id[g]`=`blocks_dispatched`, and mark core g not free;
  - `core_thread_count[g]` = `thread_count` − `blocks_dispatched`×THREADS_PER_BLOCK for the last block, otherwise THREADS_PER_BLOCK;
  - increment `blocks_dispatched`;
  - arbiter pointer moves to g+1 (mod NUM_CORES).
  - Maximum one dispatch per cycle.
- DISPATCH, completion side:
  - for every core with `core_start`=1 and `core_done`=1: next cycle `core_start`=0 and `core_reset`=1 for exactly one cycle, and `blocks_done` increments by the number of such cores (multiple completions per cycle allowed);
  - the core becomes free on the cycle after its `core_reset` strobe.
- DISPATCH exit: when `blocks_done` = `total_blocks`, go to DONE.
- DONE (1 cycle): `done`=1, `busy`=1, then IDLE.
- Disabled cores:
  - clearing `core_enable` never aborts an in-flight block; it only blocks new grants;
  - if all cores are disabled, dispatch stalls indefinitely with `busy`=1.

## Timing
- Reset values:
  - `core_start`=0, `core_reset`=all ones, `core_block_id`=0, `core_thread_count`=THREADS_PER_BLOCK;
  - `busy`=0, `done`=0, state IDLE, arbiter pointer 0.
- First IDLE cycle after `reset_n` deassertion drops `core_reset` to 0.
- Launch latency: `start` at edge N, `core_reset` high during cycle N+1, first `core_start` visible at cycle N+2.
- Completion:
  - `core_done` sampled at edge M gives `core_reset`=1 in cycle M+1;
  - the core can be re-granted at edge M+2, so `core_start` is visible at M+3.
- A completion and a dispatch in the same cycle both take effect; the just-completed core is not eligible that cycle.
- Final `core_done` at edge M: `done` pulses in cycle M+2, `busy` falls at M+3.
- `start` held high through DONE re-launches only after IDLE is re-entered; a `start` in any non-IDLE state is dropped.
- `reset_n` low mid-kernel: immediate asynchronous return to reset values; no `done` pulse.

## Structure
- `dispatch_pkg`: state enum `dispatch_state_t`; function `ceil_div` used for `total_blocks`.
- Sub-module `rr_arbiter` (NUM_CORES):
  - inputs: request vector, advance enable;
  - outputs: one-hot grant, grant index, valid;
  - owns the rotating pointer.

## Test plan
- NUM_CORES=2, TPB=4, `thread_count`=8, all enabled:
  - block 0→core 0 and block 1→core 1, each with count 4;
  - both `core_done` in the same cycle → single `done` pulse 2 cycles later.
- `thread_count`=10 with 1 core enabled: three sequential blocks with IDs 0,1,2 and counts 4,4,2; each re-grant 3 cycles after the prior `core_done`.
- `thread_count`=0 → `core_reset` strobe, no `core_start`, `done` in cycle N+2.
- `core_enable`=2'b10, `thread_count`=12 → all three blocks go to core 1; core 0's `core_start` never rises.
- Out-of-order completion, 4 cores with 6 blocks: cores finish in order 3,1,0,2; blocks 4 and 5 go to freed cores in round-robin order; `done` follows the sixth completion.
- `reset_n` pulsed low mid-DISPATCH → outputs at reset values asynchronously; a new `start` then runs normally; a `start` during `busy` is ignored.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the block dispatcher.
package dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        RESET_CORES = 2'd1,
        DISPATCH    = 2'd2,
        DONE        = 2'd3
    } dispatch_state_t;

    // Rounded-up integer division; callers keep operands well below 2^32.
    function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
        return (num + den - 32'd1) / den;
    endfunction

endpackage

// File: rtl/block_dispatcher_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating
// pointer; the pointer moves past the winner whenever the grant is taken.
module rr_arbiter #(
    parameter  int NUM_CORES = 4,
    localparam int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_CORES-1:0] request,
    input  logic                 advance,
    output logic [NUM_CORES-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 valid
);

    logic [IDX_W-1:0] ptr;

    // Search requesters starting at the pointer, wrapping around once.
    always_comb begin
        logic [IDX_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx       = '0;
        for (int off = 0; off < NUM_CORES; off++) begin
            idx = IDX_W'((int'(ptr) + off) % NUM_CORES);
            if (!valid && request[idx]) begin
                valid     = 1'b1;
                grant_idx = idx;
            end
        end
        if (valid) grant[grant_idx] = 1'b1;
    end

    // Pointer moves to the core after the one just granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance && valid) begin
            ptr <= (grant_idx == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/block_dispatcher.sv
// Splits a kernel into fixed-size thread blocks and hands them to idle,
// enabled cores; tracks out-of-order completions until the kernel is done.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | waiting for start; core_reset drops after the first cycle
// RESET_CORES | one-cycle reset strobe to every core; first grant issued
// DISPATCH    | granting blocks and retiring completions
// DONE        | one-cycle done pulse, then back to IDLE
module block_dispatcher
    import dispatch_pkg::*;
#(
    parameter  int NUM_CORES         = 4,
    parameter  int THREADS_PER_BLOCK = 4,
    parameter  int THREAD_W          = 16,
    localparam int CNT_W             = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [THREAD_W-1:0]  thread_count,
    input  logic [NUM_CORES-1:0] core_enable,
    input  logic [NUM_CORES-1:0] core_done,
    output logic [NUM_CORES-1:0] core_start,
    output logic [NUM_CORES-1:0] core_reset,
    output logic [THREAD_W-1:0]  core_block_id [NUM_CORES],
    output logic [CNT_W-1:0]     core_thread_count [NUM_CORES],
    output logic                 busy,
    output logic                 done
);

    // One extra bit so the block count cannot wrap at the maximum thread count.
    localparam int BLK_W = THREAD_W + 1;
    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    dispatch_state_t      state, state_next;
    logic [THREAD_W-1:0]  thread_count_q;
    logic [BLK_W-1:0]     total_blocks, blocks_dispatched, blocks_done, done_inc;
    logic [NUM_CORES-1:0] free_mask, request, completing, grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_valid, dispatch_ok, last_block;
    logic [CNT_W-1:0]     grant_count;

    rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .request   (request),
        .advance   (grant_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .valid     (grant_valid)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RESET_CORES;
            end
            RESET_CORES: begin
                busy       = 1'b1;
                state_next = (total_blocks == '0) ? DONE : DISPATCH;
            end
            DISPATCH: begin
                busy = 1'b1;
                if (blocks_done == total_blocks) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Arbiter requests, completions and the size of the block being granted.
    // Every core is free during RESET_CORES, so the first grant lands there.
    always_comb begin
        dispatch_ok = ((state == RESET_CORES) || (state == DISPATCH)) &&
                      (blocks_dispatched < total_blocks);
        request = '0;
        if (dispatch_ok) request = ((state == RESET_CORES) ? '1 : free_mask) & core_enable;
        completing = (state == DISPATCH) ? (core_start & core_done) : '0;
        done_inc = '0;
        for (int i = 0; i < NUM_CORES; i++) done_inc = done_inc + BLK_W'(completing[i]);
        last_block  = (blocks_dispatched == total_blocks - BLK_W'(1));
        grant_count = CNT_W'(THREADS_PER_BLOCK);
        if (last_block)
            grant_count = CNT_W'({1'b0, thread_count_q} - blocks_dispatched * BLK_W'(THREADS_PER_BLOCK));
    end

    // Kernel bookkeeping and per-core assignment registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thread_count_q    <= '0;
            total_blocks      <= '0;
            blocks_dispatched <= '0;
            blocks_done       <= '0;
            free_mask         <= '0;
            core_start        <= '0;
            core_reset        <= '1;
            for (int i = 0; i < NUM_CORES; i++) begin
                core_block_id[i]     <= '0;
                core_thread_count[i] <= CNT_W'(THREADS_PER_BLOCK);
            end
        end else begin
            case (state)
                IDLE: begin
                    core_reset <= {NUM_CORES{start}};
                    if (start) begin
                        thread_count_q    <= thread_count;
                        total_blocks      <= BLK_W'(ceil_div(32'(thread_count), 32'(THREADS_PER_BLOCK)));
                        blocks_dispatched <= '0;
                        blocks_done       <= '0;
                        free_mask         <= '0;
                    end
                end
                RESET_CORES: begin
                    core_reset <= '0;
                    core_start <= grant;
                    free_mask  <= ~grant;
                end
                DISPATCH: begin
                    // A strobed core returns to the free pool one cycle after its strobe.
                    core_reset  <= completing;
                    core_start  <= (core_start & ~completing) | grant;
                    free_mask   <= (free_mask | core_reset) & ~grant;
                    blocks_done <= blocks_done + done_inc;
                end
                default: core_reset <= '0;
            endcase
            if (grant_valid) begin
                core_block_id[grant_idx]     <= blocks_dispatched[THREAD_W-1:0];
                core_thread_count[grant_idx] <= grant_count;
                blocks_dispatched            <= blocks_dispatched + BLK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_block_dispatcher.sv
// Randomized bench for block_dispatcher with a scoreboard: a reference model
// predicts grants, strobes and done pulses; a monitor compares DUT outputs.
module tb_block_dispatcher;

    localparam int NC  = 4;
    localparam int TPB = 4;
    localparam int TW  = 16;
    localparam int CW  = $clog2(TPB) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start;
    logic [TW-1:0] thread_count;
    logic [NC-1:0] core_enable;
    logic [NC-1:0] core_done;
    logic [NC-1:0] core_start;
    logic [NC-1:0] core_reset;
    logic [TW-1:0] core_block_id [NC];
    logic [CW-1:0] core_thread_count [NC];
    logic          busy;
    logic          done;

    block_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB), .THREAD_W(TW)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .thread_count      (thread_count),
        .core_enable       (core_enable),
        .core_done         (core_done),
        .core_start        (core_start),
        .core_reset        (core_reset),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int core;
        int blk;
        int cnt;
        int edge_n;
    } disp_t;

    disp_t disp_q[$];
    int    done_q[$];
    int    n_cmp   = 0;
    int    n_fail  = 0;
    bit    aborted = 1'b0;

    // Reference model state: which cores hold a block, when each is grantable again.
    int          edge_no;
    bit          m_running, m_busy;
    int          m_launch, m_tc, m_total, m_next, m_ndone, m_ptr, m_end;
    int          free_at [NC];
    bit [NC-1:0] m_hold;
    bit [NC-1:0] exp_rst;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values();
        check("rst_core_start", core_start, 0);
        check("rst_core_reset", core_reset, (1 << NC) - 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        for (int i = 0; i < NC; i++) begin
            check("rst_block_id", core_block_id[i], 0);
            check("rst_thread_count", core_thread_count[i], TPB);
        end
    endtask

    // Reference model, evaluated on each rising edge from the inputs sampled there.
    initial begin
        int    g, c, cnt;
        disp_t d;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                edge_no   = 0;
                m_running = 1'b0;
                m_busy    = 1'b0;
                m_ptr     = 0;
                m_end     = -10;
                m_total   = 0;
                m_next    = 0;
                m_ndone   = 0;
                m_hold    = '0;
                exp_rst   = '1;
                disp_q.delete();
                done_q.delete();
            end else begin
                edge_no++;
                exp_rst = '0;
                for (int i = 0; i < NC; i++) begin
                    if (m_hold[i] && core_done[i]) begin
                        m_hold[i]  = 1'b0;
                        free_at[i] = edge_no + 2;
                        exp_rst[i] = 1'b1;
                        m_ndone++;
                        if (m_ndone == m_total) begin
                            m_end = edge_no + 1;
                            done_q.push_back(m_end);
                        end
                    end
                end
                if (m_running && edge_no > m_launch && m_next < m_total) begin
                    g = -1;
                    for (int k = 0; k < NC; k++) begin
                        c = (m_ptr + k) % NC;
                        if (g < 0 && !m_hold[c] && free_at[c] <= edge_no && core_enable[c]) g = c;
                    end
                    if (g >= 0) begin
                        cnt = m_tc - m_next * TPB;
                        if (cnt > TPB) cnt = TPB;
                        d.core   = g;
                        d.blk    = m_next;
                        d.cnt    = cnt;
                        d.edge_n = edge_no;
                        disp_q.push_back(d);
                        m_hold[g] = 1'b1;
                        m_ptr     = (g + 1) % NC;
                        m_next++;
                    end
                end
                if (m_running && edge_no == m_end + 1) begin
                    m_running = 1'b0;
                    m_busy    = 1'b0;
                end else if (!m_running && start) begin
                    m_running = 1'b1;
                    m_busy    = 1'b1;
                    m_launch  = edge_no;
                    m_tc      = int'(thread_count);
                    m_total   = (m_tc + TPB - 1) / TPB;
                    m_next    = 0;
                    m_ndone   = 0;
                    exp_rst   = '1;
                    for (int i = 0; i < NC; i++) free_at[i] = edge_no + 1;
                    if (m_total == 0) begin
                        m_end = edge_no + 1;
                        done_q.push_back(m_end);
                    end
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model just after each rising edge.
    initial begin
        logic [NC-1:0] prev;
        disp_t         d;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n) begin
                for (int i = 0; i < NC; i++) begin
                    if (core_start[i] && !prev[i]) begin
                        check("dispatch_expected", disp_q.size() > 0, 1);
                        if (disp_q.size() > 0) begin
                            d = disp_q.pop_front();
                            check("grant_core", i, d.core);
                            check("block_id", core_block_id[i], d.blk);
                            check("block_threads", core_thread_count[i], d.cnt);
                            check("grant_edge", edge_no, d.edge_n);
                        end
                    end
                end
                check("core_start", core_start, m_hold);
                check("core_reset", core_reset, exp_rst);
                check("busy", busy, m_busy);
                if (done) begin
                    check("done_expected", done_q.size() > 0, 1);
                    if (done_q.size() > 0) check("done_edge", edge_no, done_q.pop_front());
                end
            end
            prev = core_start;
        end
    end

    // Behavioural cores: random completion latency plus stray done noise while idle.
    initial begin
        core_done = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NC; i++)
                core_done[i] = core_start[i] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        end
    end

    task automatic wait_idle(input bit rnd_en);
        int c = 0;
        while (m_running && c < 3000) begin
            @(negedge clk);
            if (rnd_en && $urandom_range(0, 3) == 0) core_enable = NC'($urandom_range(0, 15));
            c++;
        end
        if (m_running) begin
            check("kernel_timeout", m_running, 0);
            aborted = 1'b1;
        end
    endtask

    task automatic launch(input int tc, input logic [NC-1:0] en, input bit wait_done, input bit rnd_en);
        if (aborted) return;
        @(negedge clk);
        core_enable  = en;
        thread_count = TW'(tc);
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (wait_done) wait_idle(rnd_en);
    endtask

    initial begin
        start        = 1'b0;
        thread_count = '0;
        core_enable  = '1;
        repeat (2) @(negedge clk);
        check_reset_values();
        reset_n = 1'b1;

        launch(8, 4'b1111, 1, 0);
        launch(10, 4'b0001, 1, 0);
        launch(0, 4'b1111, 1, 0);
        launch(12, 4'b0010, 1, 0);
        launch(24, 4'b1111, 1, 0);
        launch(TPB, 4'b1111, 1, 0);

        // All cores disabled: dispatch stalls with busy held.
        launch(8, 4'b0000, 0, 0);
        repeat (20) @(negedge clk);
        core_enable = '1;
        if (!aborted) wait_idle(0);

        // Start held high through DONE relaunches only after IDLE.
        if (!aborted) begin
            @(negedge clk);
            thread_count = 16'd6;
            start        = 1'b1;
            wait_idle(0);
            thread_count = 16'd5;
            @(negedge clk);
            start = 1'b0;
            if (!aborted) wait_idle(0);
        end

        // A start while busy is dropped.
        launch(20, 4'b1111, 0, 0);
        if (!aborted) begin
            repeat (4) @(negedge clk);
            thread_count = 16'd3;
            start        = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_idle(0);
        end

        for (int k = 0; k < 40; k++)
            launch($urandom_range(0, 41), NC'($urandom_range(1, 15)), 1, 1);

        // Asynchronous reset in the middle of a maximum-size kernel.
        launch(65535, 4'b1111, 0, 0);
        if (!aborted) begin
            repeat (30) @(negedge clk);
            #2 reset_n = 1'b0;
            #1 check_reset_values();
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
        end
        launch(9, 4'b1111, 1, 0);
        launch(13, 4'b1011, 1, 1);

        repeat (3) @(negedge clk);
        check("dispatch_queue_drained", disp_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
